// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between core load/store path and host loader
// Optional core-stall counter enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
`ifdef DMEM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stall_cnt,
`endif
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic          host_win;

  // Core owns the port by default; the host is forced through once it has waited MAX_WAIT cycles.
  assign host_win   = host_req && (!core_req || (wait_cnt_q == MAX_WAIT_C));
  assign host_gnt   = host_win;
  assign core_stall = core_req && host_win;
  assign core_rdata = mem_dat_out;

  assign mem_addr   = host_win ? host_addr  : core_addr;
  assign mem_dat_in = host_win ? host_wdata : core_wdata;
  assign mem_wr_en  = host_win ? host_we    : (core_req && core_we);

  always_comb begin
    wait_cnt_d    = 4'd0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    if (host_req && !host_win) begin
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
    if (host_win && !host_we) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = mem_dat_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= 4'd0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Clear has priority over counting a stall in the same cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = 16'd0;
    end else if (core_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port (dat_mem: dat_in, addr, wr_en, dat_out) between the core's load/store path and a host/loader port used to preload operands and read back results. Sits between the core datapath and dat_mem.
- Core has default priority.
- A starvation counter guarantees host service.
- The core is stalled (PC held) for any cycle it loses the port.

Parameters:
AW, 8, address width (matches the 8-bit ALU-result address)
DW, 8, data width
MAX_WAIT, 4, consecutive host-blocked cycles tolerated before the host is forced through (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core memory access this cycle (load or store)
core_we  in  1  core store
core_addr  in  AW  core address
core_wdata  in  DW  core store data
core_rdata  out  DW  core load data, combinational from mem_dat_out
core_stall  out  1  core lost arbitration this cycle; hold PC and instruction
host_req  in  1  host access request, level; held until granted
host_we  in  1  host write
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  host owns the port this cycle (combinational)
host_rdata  out  DW  registered host read data
host_rvalid  out  1  one-cycle pulse, cycle after a granted host read
mem_wr_en  out  1  to dat_mem wr_en
mem_addr  out  AW  to dat_mem addr
mem_dat_in  out  DW  to dat_mem dat_in
mem_dat_out  in  DW  from dat_mem dat_out (combinational read)

Behaviour:
- Reset (rst_n low, async): wait_cnt=0, host_rdata=0, host_rvalid=0. Outputs are then combinational from the inputs.
- Owner selection, combinational each cycle:
  - host wins if host_req && (!core_req || wait_cnt==MAX_WAIT)
  - otherwise core wins if core_req
  - otherwise idle: mem_wr_en=0; mem_addr/mem_dat_in driven from core inputs.
- host_gnt = host wins. core_stall = core_req && host wins. core_stall is never asserted without core_req.
- Mux: the winner's addr, wdata and we drive the mem_* outputs. mem_wr_en = winner_we && winner_req. A stalled core store must not write.
- core_rdata = mem_dat_out at all times. The core ignores it while stalled.
- wait_cnt, updated on the clock edge:
  - host_req && !host_gnt → wait_cnt+1, saturating at MAX_WAIT
  - host_gnt or !host_req → 0
- Host read: on a granted cycle with host_we=0, host_rdata<=mem_dat_out and host_rvalid<=1 on the next edge. host_rvalid is 0 in every other cycle. host_rdata holds its value until the next granted read.
- Host write: it takes effect on the grant cycle's edge. No host_rvalid.
- Simultaneous core_req and host_req with wait_cnt<MAX_WAIT: the core wins and the host waits.
- Forced host cycle: exactly one cycle. wait_cnt clears, so the core wins the following cycle even if both still request. Core worst-case stall is 1 cycle per MAX_WAIT+1.
- Host back-to-back: if host_req stays high after a grant with no core_req, the host is granted every cycle.
- Reset mid-transfer: a pending host_rvalid is cleared. The host must re-request.

Optional Feature:
DMEM_ARB_STATS_EN
- Enabled: adds a 16-bit output stall_cnt and a 1-bit input stat_clr.
  - stall_cnt increments on each cycle with core_stall=1 and saturates at 16'hFFFF.
  - stat_clr=1 synchronously zeroes it; clear wins over increment.
  - Reset value is 0.
- Disabled: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-cycle with host_req=1 → host_rvalid=0, host_rdata=0 immediately; wait_cnt=0 (first grant behaviour after release).
- Host only: host write 0x5A to addr 0x10, then host read 0x10 → host_gnt=1 both cycles; host_rvalid pulses the cycle after the read with host_rdata=0x5A.
- Core only: core store 0x33 at 0x20, load 0x20 → core_stall=0 throughout; core_rdata=0x33 on the load cycle.
- Contention, MAX_WAIT=4: core_req and host_req held high → core wins 4 cycles, host_gnt=1 with core_stall=1 on cycle 5, core wins cycle 6; the pattern repeats with period 5.
- Stalled store suppressed: core store 0xFF to 0x30 on the forced host-read cycle at 0x30 → mem_wr_en=0 that cycle. The host reads the old value; the core store lands the next cycle.
- DMEM_ARB_STATS_EN: the contention scenario run for 20 cycles → stall_cnt=4; stat_clr pulse → 0 on the next edge.
